// File: rtl/top_hw_pkg.sv
// Shared constants and state types for the UART register-access core.
package top_hw_pkg;

  // Register map addresses (full 32-bit compare)
  localparam logic [31:0] ADDR_FPGA_VERSION = 32'd0;
  localparam logic [31:0] ADDR_FPGA_ID      = 32'd1;
  localparam logic [31:0] ADDR_BUILD_DATE   = 32'd2;
  localparam logic [31:0] ADDR_SCRATCH1     = 32'd3;
  localparam logic [31:0] ADDR_SCRATCH2     = 32'd4;

  // Frame command and trailer bytes
  localparam logic [7:0] CMD_WR = 8'h5A;
  localparam logic [7:0] CMD_RD = 8'h5B;
  localparam logic [7:0] TRL_WR = 8'hA5;
  localparam logic [7:0] TRL_RD = 8'hA4;

  // Value returned for any address outside the map
  localparam logic [31:0] UNMAPPED_RD_VAL = 32'hDEAD_BEEF;

  // Frame assembler state
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EXEC,
    ST_RESPOND
  } frame_state_t;

  // UART receive engine state
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Trailer byte that must close a frame opened with the given command
  function automatic logic [7:0] trailer_for(input logic [7:0] cmd);
    return (cmd == CMD_WR) ? TRL_WR : TRL_RD;
  endfunction

endpackage

// File: rtl/top_hw_core_uart_phy.sv
// UART physical layer: RXD synchronizer, 8N1 receive engine, 8N1 transmit engine.
//
// Byte handshakes:
//   RX: o_rx_valid is a one-cycle pulse carrying o_rx_data; the stream cannot
//       stall, so the consumer must take or drop the byte in that cycle.
//       o_rx_ferr pulses instead of o_rx_valid when the stop bit samples low.
//   TX: a byte transfers on a cycle where i_tx_valid && o_tx_ready. Once
//       i_tx_valid is raised, i_tx_data must hold until that cycle. o_tx_ready
//       is also high on the final stop-bit cycle so a waiting byte starts with
//       no idle gap between frames.
module uart_phy
  import top_hw_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  output logic       o_txd,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_rx_ferr,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_tx_busy
);

  localparam logic [15:0] LP_FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LP_HALF = 16'(CLKS_PER_BIT / 2 - 1);

  logic        r_rx_meta;
  logic        r_rx_sync;
  logic        r_rx_prev;
  logic        r_rx_armed;
  rx_state_t   r_rx_state;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        r_rx_valid;
  logic        r_rx_ferr;

  logic        r_tx_busy;
  logic        r_txd;
  logic [8:0]  r_tx_shift;
  logic [3:0]  r_tx_bit;
  logic [15:0] r_tx_cnt;
  logic        w_tx_last;
  logic        w_tx_ready;

  // Receive: synchronize RXD, detect falling edge once armed, sample at mid-bit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_meta  <= 1'b0;
      r_rx_sync  <= 1'b0;
      r_rx_prev  <= 1'b0;
      r_rx_armed <= 1'b0;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_meta  <= i_rxd;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      if (r_rx_sync) begin
        r_rx_armed <= 1'b1;
      end
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_armed && r_rx_prev && !r_rx_sync) begin
            r_rx_cnt   <= LP_HALF;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == 16'd0) begin
            // A start bit that has gone high again by mid-bit is a glitch
            if (!r_rx_sync) begin
              r_rx_cnt   <= LP_FULL;
              r_rx_bit   <= 3'd0;
              r_rx_state <= RX_DATA;
            end else begin
              r_rx_state <= RX_IDLE;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == 16'd0) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_cnt   <= LP_FULL;
            if (r_rx_bit == 3'd7) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == 16'd0) begin
            r_rx_state <= RX_IDLE;
            if (r_rx_sync) begin
              r_rx_valid <= 1'b1;
            end else begin
              r_rx_ferr <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign w_tx_last  = r_tx_busy && (r_tx_bit == 4'd9) && (r_tx_cnt == 16'd0);
  assign w_tx_ready = !r_tx_busy || w_tx_last;

  // Transmit: start bit, 8 data bits LSB first, stop bit; each CLKS_PER_BIT long
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_busy  <= 1'b0;
      r_txd      <= 1'b1;
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
      r_tx_cnt   <= '0;
    end else if (i_tx_valid && w_tx_ready) begin
      r_tx_busy  <= 1'b1;
      r_txd      <= 1'b0;
      r_tx_shift <= {1'b1, i_tx_data};
      r_tx_bit   <= 4'd0;
      r_tx_cnt   <= LP_FULL;
    end else if (r_tx_busy) begin
      if (r_tx_cnt == 16'd0) begin
        if (r_tx_bit == 4'd9) begin
          r_tx_busy <= 1'b0;
          r_txd     <= 1'b1;
        end else begin
          r_txd      <= r_tx_shift[0];
          r_tx_shift <= {1'b1, r_tx_shift[8:1]};
          r_tx_bit   <= r_tx_bit + 4'd1;
          r_tx_cnt   <= LP_FULL;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt - 16'd1;
      end
    end
  end

  assign o_txd      = r_txd;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_shift;
  assign o_rx_ferr  = r_rx_ferr;
  assign o_tx_ready = w_tx_ready;
  assign o_tx_busy  = r_tx_busy;

endmodule

// File: rtl/top_hw_core.sv
// UART register-access core: assembles 10-byte command frames, executes one
// 32-bit read or write against the register file, and streams a 10-byte reply.
// The assembler state is held in r_state (frame_state_t) for probing.
module top_hw_core
  import top_hw_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int unsigned TIMEOUT_CLKS = 100000,
  parameter logic [31:0] FPGA_VERSION = 32'h0001_0000,
  parameter logic [31:0] FPGA_ID      = 32'h5354_4E31,
  parameter logic [31:0] BUILD_DATE   = 32'h2025_0101
) (
  input  logic HDW_FPGA_100M_CLK,
  input  logic HDW_DEVRST,
  input  logic HDW_DBUG_SCLK,
  output logic HDW_DBUG_HEADER2
);

  frame_state_t r_state;
  logic [7:0]   r_cmd;
  logic [31:0]  r_addr;
  logic [31:0]  r_data;
  logic [7:0]   r_trl;
  logic [3:0]   r_idx;
  logic [31:0]  r_gap;
  logic [31:0]  r_scratch1;
  logic [31:0]  r_scratch2;
  logic [31:0]  r_rsp;
  logic [3:0]   r_tx_idx;
  logic         r_all_sent;

  logic         w_rx_valid;
  logic [7:0]   w_rx_byte;
  logic         w_rx_ferr;
  logic         w_tx_valid;
  logic [7:0]   w_tx_byte;
  logic         w_tx_ready;
  logic         w_tx_busy;
  logic         w_tx_fire;
  logic         w_is_wr;
  logic [31:0]  w_rd_val;
  logic [31:0]  w_exec_val;

  uart_phy #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_phy (
    .i_clk      (HDW_FPGA_100M_CLK),
    .i_rst      (HDW_DEVRST),
    .i_rxd      (HDW_DBUG_SCLK),
    .o_txd      (HDW_DBUG_HEADER2),
    .o_rx_valid (w_rx_valid),
    .o_rx_data  (w_rx_byte),
    .o_rx_ferr  (w_rx_ferr),
    .i_tx_valid (w_tx_valid),
    .i_tx_data  (w_tx_byte),
    .o_tx_ready (w_tx_ready),
    .o_tx_busy  (w_tx_busy)
  );

  assign w_is_wr = (r_cmd == CMD_WR);

  // Register read mux against the current frame address
  always_comb begin
    w_rd_val = UNMAPPED_RD_VAL;
    case (r_addr)
      ADDR_FPGA_VERSION: w_rd_val = FPGA_VERSION;
      ADDR_FPGA_ID:      w_rd_val = FPGA_ID;
      ADDR_BUILD_DATE:   w_rd_val = BUILD_DATE;
      ADDR_SCRATCH1:     w_rd_val = r_scratch1;
      ADDR_SCRATCH2:     w_rd_val = r_scratch2;
      default:           w_rd_val = UNMAPPED_RD_VAL;
    endcase
  end

  // Value reported back: a write to a scratchpad returns the new data
  always_comb begin
    w_exec_val = w_rd_val;
    if (w_is_wr && ((r_addr == ADDR_SCRATCH1) || (r_addr == ADDR_SCRATCH2))) begin
      w_exec_val = r_data;
    end
  end

  // The CMD echo is known before EXEC finishes, so the first byte is offered
  // in EXEC to get the start bit out as early as possible.
  assign w_tx_valid = (r_state == ST_EXEC) || ((r_state == ST_RESPOND) && !r_all_sent);
  assign w_tx_fire  = w_tx_valid && w_tx_ready;

  // Response byte selector: CMD, ADDR[31:0], value[31:0], TRAILER
  always_comb begin
    w_tx_byte = r_trl;
    case (r_tx_idx)
      4'd0:    w_tx_byte = r_cmd;
      4'd1:    w_tx_byte = r_addr[31:24];
      4'd2:    w_tx_byte = r_addr[23:16];
      4'd3:    w_tx_byte = r_addr[15:8];
      4'd4:    w_tx_byte = r_addr[7:0];
      4'd5:    w_tx_byte = r_rsp[31:24];
      4'd6:    w_tx_byte = r_rsp[23:16];
      4'd7:    w_tx_byte = r_rsp[15:8];
      4'd8:    w_tx_byte = r_rsp[7:0];
      default: w_tx_byte = r_trl;
    endcase
  end

  // Frame assembler, register file update and response sequencing
  always_ff @(posedge HDW_FPGA_100M_CLK) begin
    if (HDW_DEVRST) begin
      r_state    <= ST_IDLE;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_trl      <= '0;
      r_idx      <= '0;
      r_gap      <= '0;
      r_scratch1 <= '0;
      r_scratch2 <= '0;
      r_rsp      <= '0;
      r_tx_idx   <= '0;
      r_all_sent <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_gap      <= '0;
          r_tx_idx   <= '0;
          r_all_sent <= 1'b0;
          if (w_rx_valid && ((w_rx_byte == CMD_WR) || (w_rx_byte == CMD_RD))) begin
            r_cmd   <= w_rx_byte;
            r_idx   <= 4'd1;
            r_state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (w_rx_ferr) begin
            r_state <= ST_IDLE;
          end else if (w_rx_valid) begin
            r_gap <= '0;
            r_idx <= r_idx + 4'd1;
            if (r_idx <= 4'd4) begin
              r_addr <= {r_addr[23:0], w_rx_byte};
            end else if (r_idx <= 4'd8) begin
              r_data <= {r_data[23:0], w_rx_byte};
            end else begin
              r_trl   <= w_rx_byte;
              r_state <= (w_rx_byte == trailer_for(r_cmd)) ? ST_EXEC : ST_IDLE;
            end
          end else if (r_gap >= TIMEOUT_CLKS) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap + 32'd1;
          end
        end
        ST_EXEC: begin
          if (w_is_wr && (r_addr == ADDR_SCRATCH1)) begin
            r_scratch1 <= r_data;
          end
          if (w_is_wr && (r_addr == ADDR_SCRATCH2)) begin
            r_scratch2 <= r_data;
          end
          r_rsp    <= w_exec_val;
          r_tx_idx <= w_tx_fire ? 4'd1 : 4'd0;
          r_state  <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (w_tx_fire) begin
            if (r_tx_idx == 4'd9) begin
              r_all_sent <= 1'b1;
            end else begin
              r_tx_idx <= r_tx_idx + 4'd1;
            end
          end
          if (r_all_sent && !w_tx_busy) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_top_hw_core.sv
// Bench for top_hw_core: drives UART command frames, decodes the TX line and
// scores each response against a register-map model.
module tb_top_hw_core;

  localparam int CPB = 8;
  localparam int TO  = 200;

  logic clk;
  logic rst;
  logic rxd;
  logic txd;

  int unsigned cyc;
  int          n_total;
  int          n_bad;

  logic [7:0]  mon_byte_q[$];
  int unsigned mon_start_q[$];
  int          mon_stop_bad;
  logic [79:0] exp_q[$];
  int unsigned trl_stop_cyc;

  logic [31:0] m_s1;
  logic [31:0] m_s2;

  top_hw_core #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .HDW_FPGA_100M_CLK (clk),
    .HDW_DEVRST        (rst),
    .HDW_DBUG_SCLK     (rxd),
    .HDW_DBUG_HEADER2  (txd)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-map reference model
  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0001_0000;
      32'd1:   return 32'h5354_4E31;
      32'd2:   return 32'h2025_0101;
      32'd3:   return m_s1;
      32'd4:   return m_s2;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if (a == 32'd3) m_s1 = d;
    if (a == 32'd4) m_s2 = d;
  endtask

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // TX monitor: decode bytes at mid-bit, record each start-bit cycle
  initial begin
    logic [7:0]  b;
    int unsigned st;
    mon_stop_bad = 0;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        st = cyc;
        repeat (CPB / 2 - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        if (txd !== 1'b1) mon_stop_bad++;
        mon_byte_q.push_back(b);
        mon_start_q.push_back(st);
      end
    end
  end

  // Drive one 8N1 byte; caller is positioned on a negedge
  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_val;
    trl_stop_cyc = cyc;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a,
                            input logic [31:0] d, input logic [7:0] trl);
    logic [79:0] f;
    f = {cmd, a, d, trl};
    @(negedge clk);
    for (int i = 9; i >= 0; i--) send_byte(f[i*8 +: 8], 1'b1);
  endtask

  task automatic flush_mon();
    mon_byte_q.delete();
    mon_start_q.delete();
  endtask

  // One scored transaction: model update, send, collect, compare, timing
  task automatic do_txn(input string tag, input logic [7:0] cmd,
                        input logic [31:0] a, input logic [31:0] d);
    logic [7:0]  trl;
    logic [79:0] got;
    int unsigned lat;
    logic        ok;
    trl = (cmd == 8'h5A) ? 8'hA5 : 8'hA4;
    if (cmd == 8'h5A) model_write(a, d);
    exp_q.push_back({cmd, a, model_read(a), trl});
    send_frame(cmd, a, d, trl);
    for (int k = 0; k < 3000 && mon_byte_q.size() < 10; k++) @(negedge clk);
    repeat (12 * CPB) @(negedge clk);
    chk({tag, "_len"}, 80'(mon_byte_q.size()), 80'd10);
    if (mon_byte_q.size() >= 10) begin
      got = '0;
      for (int i = 0; i < 10; i++) got = {got[71:0], mon_byte_q[i]};
      chk(tag, got, exp_q.pop_front());
      lat = mon_start_q[0] - trl_stop_cyc;
      ok = (lat >= CPB / 2) && (lat <= CPB / 2 + 7);
      chk({tag, "_lat"}, {79'd0, ok}, 80'd1);
      ok = 1'b1;
      for (int i = 1; i < 10; i++)
        if (mon_start_q[i] - mon_start_q[i-1] != 10 * CPB) ok = 1'b0;
      chk({tag, "_contig"}, {79'd0, ok}, 80'd1);
    end else begin
      void'(exp_q.pop_front());
    end
    flush_mon();
  endtask

  task automatic expect_silence(input string tag);
    repeat (30 * CPB) @(negedge clk);
    chk(tag, 80'(mon_byte_q.size()), 80'd0);
    flush_mon();
  endtask

  initial begin
    logic [7:0]  c;
    logic [31:0] a;
    cyc = 0; n_total = 0; n_bad = 0;
    m_s1 = '0; m_s2 = '0;
    rxd = 1'b1;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_txd", {79'd0, txd}, 80'd1);
    rst = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    chk("idle_txd", {79'd0, txd}, 80'd1);

    do_txn("rd_ver",   8'h5B, 32'd0, 32'd0);
    do_txn("rd_id",    8'h5B, 32'd1, 32'd0);
    do_txn("rd_date",  8'h5B, 32'd2, 32'd0);
    do_txn("wr_s1",    8'h5A, 32'd3, 32'h1234_5678);
    do_txn("wr_s2",    8'h5A, 32'd4, 32'h8765_4321);
    do_txn("rd_s1",    8'h5B, 32'd3, 32'd0);
    do_txn("rd_s2",    8'h5B, 32'd4, 32'd0);
    do_txn("wr_ro",    8'h5A, 32'd0, 32'hFFFF_FFFF);
    do_txn("rd_unmap", 8'h5B, 32'd9, 32'd0);

    // Read frame with write trailer is dropped
    send_frame(8'h5B, 32'd0, 32'd0, 8'hA5);
    expect_silence("bad_trl_quiet");
    do_txn("rd_after_badtrl", 8'h5B, 32'd1, 32'd0);

    // Garbage lead byte
    @(negedge clk);
    send_byte(8'h00, 1'b1);
    expect_silence("garbage_quiet");
    do_txn("rd_after_garbage", 8'h5B, 32'd2, 32'd0);

    // Partial frame then a gap well beyond the timeout
    @(negedge clk);
    send_byte(8'h5B, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (2 * TO + 50) @(negedge clk);
    chk("timeout_quiet", 80'(mon_byte_q.size()), 80'd0);
    flush_mon();
    do_txn("rd_after_timeout", 8'h5B, 32'd3, 32'd0);

    // Framing error mid-frame returns the assembler to IDLE
    @(negedge clk);
    send_byte(8'h5B, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    expect_silence("ferr_quiet");
    do_txn("rd_after_ferr", 8'h5B, 32'd4, 32'd0);

    chk("tx_stop_bits", 80'(mon_stop_bad), 80'd0);

    // Reset in the middle of a response: TXD high on the next clock
    send_frame(8'h5B, 32'd3, 32'd0, 8'hA4);
    for (int k = 0; k < 3000 && mon_byte_q.size() < 2; k++) @(negedge clk);
    for (int k = 0; k < 10 * CPB && txd !== 1'b0; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_txd", {79'd0, txd}, 80'd1);
    m_s1 = '0; m_s2 = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    flush_mon();
    mon_stop_bad = 0;
    do_txn("rd_s1_after_rst", 8'h5B, 32'd3, 32'd0);
    do_txn("rd_s2_after_rst", 8'h5B, 32'd4, 32'd0);

    // Randomized reads and writes over mapped, near-boundary and wild addresses
    for (int n = 0; n < 12; n++) begin
      c = ($urandom_range(0, 1) == 0) ? 8'h5A : 8'h5B;
      case ($urandom_range(0, 3))
        0:       a = 32'($urandom_range(0, 6));
        1:       a = 32'($urandom_range(3, 4));
        2:       a = $urandom;
        default: a = 32'($urandom_range(0, 4));
      endcase
      do_txn("rnd", c, a, $urandom);
    end

    chk("tx_stop_bits_end", 80'(mon_stop_bad), 80'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
